// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared widths, constants and write-bus type for the register file
package cpu_defs;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [RegBus-1:0] ZeroWord  = '0;
  localparam logic              RstEnable = 1'b0;

  // we is already qualified: enabled, not stalled, non-zero destination
  typedef struct packed {
    logic                  we;
    logic [RegAddrBus-1:0] waddr;
    logic [RegBus-1:0]     wdata;
  } reg_wr_t;
endpackage

// File: rtl/regfile_rd_port.sv
// rtl/regfile_rd_port.sv - one combinational read port: disable/zero-register masking
// and, with REGFILE_BYPASS_EN, same-cycle forwarding of accepted writes (slot 2 first).
module regfile_rd_port
  import cpu_defs::*;
#(
  parameter int DW = RegBus
) (
  input  logic                  re,
  input  logic [RegAddrBus-1:0] raddr,
  input  logic [DW-1:0]         arr_word,
`ifdef REGFILE_BYPASS_EN
  input  reg_wr_t               wr1,
  input  reg_wr_t               wr2,
`endif
  output logic [DW-1:0]         rdata
);

  always_comb begin
    rdata = ZeroWord;
    if (re && (raddr != '0)) begin
`ifdef REGFILE_BYPASS_EN
      if (wr2.we && (wr2.waddr == raddr)) begin
        rdata = wr2.wdata;
      end else if (wr1.we && (wr1.waddr == raddr)) begin
        rdata = wr1.wdata;
      end else begin
        rdata = arr_word;
      end
`else
      rdata = arr_word;
`endif
    end
  end

endmodule

// File: rtl/regfile_dual_wb.sv
// rtl/regfile_dual_wb.sv - dual write-back, quad read register file; r0 hardwired to zero.
// Optional same-cycle write forwarding selected by REGFILE_BYPASS_EN.
module regfile_dual_wb
  import cpu_defs::*;
#(
  parameter int NREG = 32,
  parameter int DW   = RegBus
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall_wb,
  input  logic                           we1,
  input  logic [RegAddrBus-1:0]          waddr1,
  input  logic [DW-1:0]                  wdata1,
  input  logic                           we2,
  input  logic [RegAddrBus-1:0]          waddr2,
  input  logic [DW-1:0]                  wdata2,
  input  logic [3:0]                     re,
  input  logic [3:0][RegAddrBus-1:0]     raddr,
  output logic [3:0][DW-1:0]             rdata,
  output logic                           wr_conflict
);

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];
  logic          wr_conflict_q;
  logic          wr_conflict_d;
  reg_wr_t       wr1;
  reg_wr_t       wr2;

  always_comb begin
    wr1.we    = we1 && !stall_wb && (waddr1 != '0);
    wr1.waddr = waddr1;
    wr1.wdata = wdata1;
    wr2.we    = we2 && !stall_wb && (waddr2 != '0);
    wr2.waddr = waddr2;
    wr2.wdata = wdata2;
  end

  // Slot 2 is applied last so the younger instruction wins a same-address collision
  always_comb begin
    mem_d = mem_q;
    if (wr1.we) mem_d[wr1.waddr] = wr1.wdata;
    if (wr2.we) mem_d[wr2.waddr] = wr2.wdata;
    wr_conflict_d = wr1.we && wr2.we && (wr1.waddr == wr2.waddr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign wr_conflict = wr_conflict_q;

  for (genvar k = 0; k < 4; k++) begin : g_rd
    regfile_rd_port #(.DW(DW)) u_rd (
      .re       (re[k]),
      .raddr    (raddr[k]),
      .arr_word (mem_q[raddr[k]]),
`ifdef REGFILE_BYPASS_EN
      .wr1      (wr1),
      .wr2      (wr2),
`endif
      .rdata    (rdata[k])
    );
  end

endmodule

// File: tb/tb_regfile_dual_wb.sv
// tb/tb_regfile_dual_wb.sv - self-checking bench: register-file model compared every cycle
// plus directed literal checks; honours REGFILE_BYPASS_EN.
module tb_regfile_dual_wb;
  logic             clk = 1'b0;
  logic             rst;
  logic             stall_wb;
  logic             we1, we2;
  logic [4:0]       waddr1, waddr2;
  logic [31:0]      wdata1, wdata2;
  logic [3:0]       re;
  logic [3:0][4:0]  raddr;
  logic [3:0][31:0] rdata;
  logic             wr_conflict;

  int checks   = 0;
  int failures = 0;
  bit bypass_on;

  logic [31:0] model_reg [32];
  logic        model_conf;

  regfile_dual_wb dut (
    .clk(clk), .rst(rst), .stall_wb(stall_wb),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .we2(we2), .waddr2(waddr2), .wdata2(wdata2),
    .re(re), .raddr(raddr), .rdata(rdata), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an array of 32 words where index 0 is never written
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) model_reg[i] = '0;
      model_conf = 1'b0;
    end else begin
      model_conf = 1'b0;
      if (!stall_wb) begin
        if (we1 && waddr1 != 0) model_reg[waddr1] = wdata1;
        if (we2 && waddr2 != 0) model_reg[waddr2] = wdata2;
        model_conf = we1 && we2 && waddr1 != 0 && waddr1 == waddr2;
      end
    end
  end

  function automatic logic [31:0] expect_rd(input int k);
    if (!re[k] || raddr[k] == 0) return 32'h0;
    if (bypass_on && !stall_wb) begin
      if (we2 && waddr2 == raddr[k]) return wdata2;
      if (we1 && waddr1 == raddr[k]) return wdata1;
    end
    return model_reg[raddr[k]];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) check($sformatf("model_rdata%0d", k), rdata[k], expect_rd(k));
    check("model_wr_conflict", {31'b0, wr_conflict}, {31'b0, model_conf});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic no_wr();
    we1 = 0; we2 = 0; stall_wb = 0;
  endtask

  task automatic wr(input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                    input logic e2, input logic [4:0] a2, input logic [31:0] d2);
    we1 = e1; waddr1 = a1; wdata1 = d1;
    we2 = e2; waddr2 = a2; wdata2 = d2;
  endtask

  initial begin
`ifdef REGFILE_BYPASS_EN
    bypass_on = 1'b1;
`else
    bypass_on = 1'b0;
`endif
    rst = 0; stall_wb = 0;
    wr(0, 0, 0, 0, 0, 0);
    re = 4'hF; raddr = '0;
    tick(); tick();
    rst = 1;
    raddr[0] = 5; raddr[1] = 7; raddr[2] = 3; raddr[3] = 31;
    @(negedge clk);
    for (int k = 0; k < 4; k++) check($sformatf("reset_rdata%0d", k), rdata[k], 32'h0);
    check("reset_wr_conflict", {31'b0, wr_conflict}, 32'h0);

    tick();
    wr(1, 5, 32'h1234_5678, 0, 0, 0);
    tick(); no_wr();
    raddr[0] = 5;
    @(negedge clk);
    check("r5_readback", rdata[0], 32'h1234_5678);

    tick();
    wr(1, 0, 32'hFFFF_FFFF, 1, 0, 32'hAAAA_AAAA);
    raddr[0] = 0;
    tick(); no_wr();
    @(negedge clk);
    check("r0_zero", rdata[0], 32'h0);
    check("r0_no_conflict", {31'b0, wr_conflict}, 32'h0);

    tick();
    wr(1, 7, 32'h11, 1, 7, 32'h22);
    tick(); no_wr();
    raddr[0] = 7;
    @(negedge clk);
    check("r7_slot2_wins", rdata[0], 32'h22);
    check("conflict_set", {31'b0, wr_conflict}, 32'h1);
    tick();
    @(negedge clk);
    check("conflict_clear", {31'b0, wr_conflict}, 32'h0);

    tick();
    wr(1, 3, 32'h5, 0, 0, 0);
    tick();
    wr(1, 3, 32'h9, 0, 0, 0); stall_wb = 1;
    tick(); no_wr();
    raddr[0] = 3;
    @(negedge clk);
    check("stall_holds_r3", rdata[0], 32'h5);
    tick();
    wr(1, 3, 32'h9, 0, 0, 0);
    tick(); no_wr();
    @(negedge clk);
    check("r3_after_stall", rdata[0], 32'h9);

    tick();
    wr(1, 4, 32'h1111, 0, 0, 0);
    tick();
    wr(0, 0, 0, 1, 4, 32'hCAFE);
    re[1] = 1; raddr[1] = 4;
    @(negedge clk);
    check("same_cycle_r4", rdata[1], bypass_on ? 32'hCAFE : 32'h1111);
    tick(); no_wr();
    @(negedge clk);
    check("next_cycle_r4", rdata[1], 32'hCAFE);

    tick();
    re[2] = 0; raddr[2] = 7;
    @(negedge clk);
    check("read_disable", rdata[2], 32'h0);
    re[2] = 1;
    #1;
    check("read_enable_r7", rdata[2], 32'h22);

    tick();
    raddr[0] = 5; raddr[1] = 7; raddr[2] = 3; raddr[3] = 4;
    #2;
    rst = 0;
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("midrun_reset_rdata%0d", k), rdata[k], 32'h0);
    tick();
    rst = 1;
    wr(1, 5, 32'h1234_5678, 0, 0, 0);
    tick(); no_wr();
    @(negedge clk);
    check("post_reset_r5", rdata[0], 32'h1234_5678);
    check("post_reset_r7", rdata[1], 32'h0);

    for (int i = 0; i < 40; i++) begin
      tick();
      wr($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
         $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
      stall_wb = ($urandom_range(0, 5) == 0);
      re = 4'($urandom);
      for (int k = 0; k < 4; k++) raddr[k] = 5'($urandom_range(0, 7));
    end
    tick(); no_wr();
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_dual_wb.md
# regfile_dual_wb

Dual-issue architectural register file: the write-back end of the operand-forwarding path. It accepts up to two retiring results per cycle from write-back slots 1 and 2 and serves four read ports (rs/rt for each issue slot) to decode and the operand-forwarding stage. It sits between the MEM/WB pipeline register and the ID-stage operand fetch.

## Interface
- Parameters
  - NREG, 32, number of architectural registers; address width is `$clog2(NREG)` (5).
  - DW, 32, data width.
- Ports
  - clk  in  1  rising-edge clock.
  - rst  in  1  asynchronous, active-low reset.
  - stall_wb  in  1  write-back stalled; suppresses both writes this cycle.
  - we1  in  1  slot-1 (older instruction) write enable.
  - waddr1  in  5  slot-1 destination.
  - wdata1  in  DW  slot-1 result.
  - we2  in  1  slot-2 (younger instruction) write enable.
  - waddr2  in  5  slot-2 destination.
  - wdata2  in  DW  slot-2 result.
  - re[k], k = 0..3  in  1  read enable, one per read port.
  - raddr[k], k = 0..3  in  5  read address, one per read port.
  - rdata[k], k = 0..3  out  DW  read data, one per read port.
  - wr_conflict  out  1  registered flag: the previous accepted cycle had both writes to the same non-zero address.

## Operation
- Storage: registers 1..NREG-1. Register 0 is hardwired to zero; writes to it are discarded.
- Accepted write: a write with `we=1`, address ≠ 0 and `stall_wb=0`.
- Commit at posedge clk:
  - If both accepted writes target the same address, slot 2 wins (it is the younger instruction). The slot-1 data is dropped.
  - Otherwise both writes commit in the same edge.
- Reads are combinational:
  - `re=0` → read data is 0.
  - `raddr=0` → read data is 0.
  - Otherwise read data is the stored value, subject to the bypass rule under Configuration.
- wr_conflict:
  - Set at posedge when both writes are accepted and waddr1 == waddr2 ≠ 0.
  - Cleared at the next posedge where that condition is false.
  - It is a debug/perf signal only.
- Reset (asynchronous, rst=0):
  - All storage registers clear to 0 immediately.
  - wr_conflict clears to 0.
  - Writes presented while rst=0 are ignored.
  - Reads during reset return 0, or the bypassed write data when bypass is enabled (see Configuration).
- No FSM. The sequential state is the register array plus the wr_conflict flop.

## Timing
- Write latency: data written at edge N is visible through the array from edge N onward; the read in cycle N+1 sees it.
- Same-cycle read-after-write: governed by REGFILE_BYPASS_EN (below).
- stall_wb=1 suppresses both commits for that edge. The register array holds all values.
- Reset deassertion is not synchronized internally; it is synchronized upstream. The first write can commit at the first posedge with rst=1.
- Read paths are combinational: raddr→rdata with no register, so the forwarding stage samples them at its own clock edge.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - An accepted write in the current cycle is forwarded to any read port with a matching non-zero address.
  - Priority: slot 2, then slot 1, then the array.
  - Removes the "write-back → decode" hazard window from the forwarding unit.
- Undefined:
  - Reads return the array contents only.
  - A same-cycle write is not visible until the following cycle.
  - The forwarding unit must cover this case.

## Structure
- Shared package (`cpu_defs`):
  - RegBus / RegAddrBus widths.
  - ZeroWord.
  - RstEnable polarity constant for active-low.
  - `reg_wr_t` struct {we, waddr, wdata}.
- Sub-module `regfile_rd_port`:
  - One per read port, four instances.
  - Inputs: re, raddr, array word, both `reg_wr_t` buses.
  - Implements zero / disable / bypass priority.
  - Bypass logic inside it is conditional on the macro.

## Test plan
- Reset and basic write/read:
  - Pulse rst=0 mid-run with registers written → all rdata 0 immediately.
  - After release, write we1 r5=0x1234_5678, then read raddr0=5 next cycle → 0x1234_5678.
- $zero write:
  - we1 r0=0xFFFF_FFFF, we2 r0=0xAAAA_AAAA → read r0 = 0; wr_conflict stays 0.
- Same-address dual write:
  - we1 r7=0x11, we2 r7=0x22 → r7 reads 0x22 next cycle; wr_conflict=1 for one cycle, then 0.
- stall_wb:
  - r3=0x5, then stall_wb=1 with we1 r3=0x9 → r3 still 0x5.
  - Release the stall and repeat the write → r3 reads 0x9.
- Same-cycle bypass:
  - Present we2 r4=0xCAFE with raddr1=4, re=1.
  - With REGFILE_BYPASS_EN: rdata1=0xCAFE the same cycle.
  - Without it: old r4 value that cycle, 0xCAFE the next cycle.
- Read disable:
  - re[2]=0, raddr[2]=7 holding 0x22 → rdata2=0.
